// File: rtl/mem_sort_controller_if.sv
// Data-memory port shared between the sort sequencer (master) and datamemory/arbiter (slave).
// Read data is combinational; writes commit on the rising clock edge.
interface mem_sort_controller_if;
  logic        mem_req;
  logic        mem_gnt;
  logic [63:0] address;
  logic [63:0] write_data;
  logic        memoryread;
  logic        memorywrite;
  logic [63:0] read_data;

  modport master (
    output mem_req, address, write_data, memoryread, memorywrite,
    input  mem_gnt, read_data
  );

  modport slave (
    input  mem_req, address, write_data, memoryread, memorywrite,
    output mem_gnt, read_data
  );
endinterface

// File: rtl/mem_sort_controller.sv
// In-place ascending bubble sort of N 64-bit words in data memory.
// Owns the memory port through a req/gnt handshake; reports pass and swap counts.
module mem_sort_controller #(
  parameter int unsigned N         = 10,
  parameter logic [63:0] BASE_ADDR = 64'd0,
  parameter bit          SIGNED    = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           pass_count,
  output logic [15:0]           swap_count,
  mem_sort_controller_if.master mem
);

  localparam int unsigned IDX_W  = 10;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DATA_W = 64;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  typedef enum logic [2:0] {
    IDLE, RD_A, RD_B, WR_A, WR_B, NEXT, DONE
  } state_t;

  state_t              state, state_d;
  logic [IDX_W-1:0]    i_q, i_d, j_q, j_d;
  logic                swapped_q, swapped_d;
  logic [DATA_W-1:0]   tmp_a_q, tmp_a_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    pass_d, swap_d;
  logic                rd_c, wr_c, greater_c, pass_end_c, last_pass_c;

  function automatic logic [DATA_W-1:0] slot(input logic [IDX_W-1:0] k);
    return BASE_ADDR + (DATA_W'(k) << 3);
  endfunction

  assign greater_c   = SIGNED ? ($signed(tmp_a_q) > $signed(mem.read_data))
                              : (tmp_a_q > mem.read_data);
  assign pass_end_c  = (j_q + IDX_W'(1)) == (LAST - i_q);
  assign last_pass_c = (i_q + IDX_W'(1)) == LAST;

  // State and datapath registers; strobes derive from state so reset kills them at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      i_q        <= '0;
      j_q        <= '0;
      swapped_q  <= 1'b0;
      tmp_a_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      pass_count <= '0;
      swap_count <= '0;
    end else begin
      state      <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      swapped_q  <= swapped_d;
      tmp_a_q    <= tmp_a_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      pass_count <= pass_d;
      swap_count <= swap_d;
    end
  end

  // Next-state logic; every memory state holds completely while the port is not granted.
  always_comb begin
    state_d   = state;
    i_d       = i_q;
    j_d       = j_q;
    swapped_d = swapped_q;
    tmp_a_d   = tmp_a_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    pass_d    = pass_count;
    swap_d    = swap_count;
    rd_c      = 1'b0;
    wr_c      = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          i_d       = '0;
          j_d       = '0;
          swapped_d = 1'b0;
          pass_d    = '0;
          swap_d    = '0;
          if (N < 2) begin
            state_d = DONE;
          end else begin
            state_d = RD_A;
            addr_d  = slot('0);
          end
        end
      end
      RD_A: begin
        if (mem.mem_gnt) begin
          rd_c    = 1'b1;
          tmp_a_d = mem.read_data;
          state_d = RD_B;
          addr_d  = slot(j_q + IDX_W'(1));
        end
      end
      RD_B: begin
        // The write-data register doubles as the captured second operand.
        if (mem.mem_gnt) begin
          rd_c    = 1'b1;
          wdata_d = mem.read_data;
          if (greater_c) begin
            state_d = WR_A;
            addr_d  = slot(j_q);
          end else begin
            state_d = NEXT;
          end
        end
      end
      WR_A: begin
        if (mem.mem_gnt) begin
          wr_c    = 1'b1;
          state_d = WR_B;
          addr_d  = slot(j_q + IDX_W'(1));
          wdata_d = tmp_a_q;
        end
      end
      WR_B: begin
        if (mem.mem_gnt) begin
          wr_c      = 1'b1;
          state_d   = NEXT;
          swapped_d = 1'b1;
          swap_d    = (swap_count == '1) ? swap_count : swap_count + CNT_W'(1);
        end
      end
      NEXT: begin
        if (mem.mem_gnt) begin
          if (pass_end_c) begin
            pass_d = pass_count + CNT_W'(1);
            if (!swapped_q || last_pass_c) begin
              state_d = DONE;
            end else begin
              state_d   = RD_A;
              i_d       = i_q + IDX_W'(1);
              j_d       = '0;
              swapped_d = 1'b0;
              addr_d    = slot('0);
            end
          end else begin
            state_d = RD_A;
            j_d     = j_q + IDX_W'(1);
            addr_d  = slot(j_q + IDX_W'(1));
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy            = (state != IDLE);
  assign done            = (state == DONE);
  assign mem.mem_req     = (state inside {RD_A, RD_B, WR_A, WR_B, NEXT});
  assign mem.memoryread  = rd_c;
  assign mem.memorywrite = wr_c;
  assign mem.address     = addr_q;
  assign mem.write_data  = wdata_q;

endmodule

// File: tb/tb_mem_sort_controller.sv
// Directed bench for mem_sort_controller: table of sort vectors on a 10-word memory,
// plus signed/unsigned two-word sorts, an N=1 block, and a mid-swap reset sequence.
module tb_mem_sort_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start_m, start_s;
  logic busy_m, done_m, busy_s, done_s, busy_u, done_u, busy_o, done_o;
  logic [15:0] pass_m, swap_m, pass_s, swap_s, pass_u, swap_u, pass_o, swap_o;

  mem_sort_controller_if bus_m();
  mem_sort_controller_if bus_s();
  mem_sort_controller_if bus_u();
  mem_sort_controller_if bus_o();

  mem_sort_controller #(.N(10), .BASE_ADDR(64'd0), .SIGNED(1'b0)) dut_m (
    .clk(clk), .reset(reset), .start(start_m), .busy(busy_m), .done(done_m),
    .pass_count(pass_m), .swap_count(swap_m), .mem(bus_m));
  mem_sort_controller #(.N(2), .BASE_ADDR(64'h100), .SIGNED(1'b1)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .busy(busy_s), .done(done_s),
    .pass_count(pass_s), .swap_count(swap_s), .mem(bus_s));
  mem_sort_controller #(.N(2), .BASE_ADDR(64'h100), .SIGNED(1'b0)) dut_u (
    .clk(clk), .reset(reset), .start(start_s), .busy(busy_u), .done(done_u),
    .pass_count(pass_u), .swap_count(swap_u), .mem(bus_u));
  mem_sort_controller #(.N(1), .BASE_ADDR(64'd0), .SIGNED(1'b0)) dut_o (
    .clk(clk), .reset(reset), .start(start_s), .busy(busy_o), .done(done_o),
    .pass_count(pass_o), .swap_count(swap_o), .mem(bus_o));

  // Main memory: ten words at address 0, combinational read, write on rising edge.
  logic [63:0]      mem_m [10];
  logic [9:0][63:0] load_img;
  logic             load_m;
  logic [60:0]      idx_m;
  logic             gnt_m;
  bit               stall_mode;
  int               gcyc;

  assign idx_m          = bus_m.address[63:3];
  assign bus_m.read_data = (idx_m < 61'd10) ? mem_m[idx_m[3:0]] : 64'd0;
  assign bus_m.mem_gnt   = gnt_m;

  always @(posedge clk) begin
    if (load_m) begin
      for (int k = 0; k < 10; k++) mem_m[k] <= load_img[k];
    end else if (bus_m.memorywrite && idx_m < 61'd10) begin
      mem_m[idx_m[3:0]] <= bus_m.write_data;
    end
  end

  // Grant withdrawn one cycle in three while stall_mode is set.
  always @(negedge clk) begin
    gcyc  = gcyc + 1;
    gnt_m = (stall_mode && (gcyc % 3 == 0)) ? 1'b0 : 1'b1;
  end

  // Two-word memories at 0x100 for the signed and unsigned instances.
  logic [63:0]      mem_s [2];
  logic [63:0]      mem_u [2];
  logic [1:0][63:0] img2;
  logic             load_sm;
  logic [63:0]      idx_s, idx_u;

  assign idx_s = (bus_s.address - 64'h100) >> 3;
  assign idx_u = (bus_u.address - 64'h100) >> 3;
  assign bus_s.read_data = (idx_s < 64'd2) ? mem_s[idx_s[0]] : 64'd0;
  assign bus_u.read_data = (idx_u < 64'd2) ? mem_u[idx_u[0]] : 64'd0;
  assign bus_s.mem_gnt   = 1'b1;
  assign bus_u.mem_gnt   = 1'b1;
  assign bus_o.mem_gnt   = 1'b1;
  assign bus_o.read_data = 64'd0;

  always @(posedge clk) begin
    if (load_sm) begin
      mem_s[0] <= img2[0]; mem_s[1] <= img2[1];
      mem_u[0] <= img2[0]; mem_u[1] <= img2[1];
    end else begin
      if (bus_s.memorywrite && idx_s < 64'd2) mem_s[idx_s[0]] <= bus_s.write_data;
      if (bus_u.memorywrite && idx_u < 64'd2) mem_u[idx_u[0]] <= bus_u.write_data;
    end
  end

  // Sticky protocol monitors, sampled mid-cycle.
  int viol_m = 0;
  int viol_o = 0;
  always @(posedge clk) begin
    #2;
    if ((!bus_m.mem_gnt && (bus_m.memoryread || bus_m.memorywrite)) ||
        (bus_m.memoryread && bus_m.memorywrite) ||
        ((bus_m.memoryread || bus_m.memorywrite) && !bus_m.mem_req))
      viol_m = viol_m + 1;
    if (bus_o.mem_req || bus_o.memoryread || bus_o.memorywrite)
      viol_o = viol_o + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_mem(input string name, input logic [9:0][63:0] exp);
    int bad;
    bad = -1;
    n_checks++;
    for (int k = 0; k < 10; k++)
      if (mem_m[k] !== exp[k] && bad < 0) bad = k;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: word %0d got 0x%0h, expected 0x%0h", name, bad, mem_m[bad], exp[bad]);
    end
  endtask

  // Reference ordering by selection sort, unsigned.
  function automatic logic [9:0][63:0] model_sort(input logic [9:0][63:0] d);
    logic [9:0][63:0] r;
    logic [63:0] t;
    r = d;
    for (int a = 0; a < 9; a++)
      for (int b = a + 1; b < 10; b++)
        if (r[b] < r[a]) begin t = r[a]; r[a] = r[b]; r[b] = t; end
    return r;
  endfunction

  function automatic int inversions(input logic [9:0][63:0] d);
    int n;
    n = 0;
    for (int a = 0; a < 9; a++)
      for (int b = a + 1; b < 10; b++)
        if (d[a] > d[b]) n++;
    return n;
  endfunction

  task automatic preload(input logic [9:0][63:0] d);
    @(negedge clk);
    load_img = d;
    load_m   = 1'b1;
    @(posedge clk); #1;
    load_m   = 1'b0;
  endtask

  task automatic pulse_start_m();
    @(negedge clk);
    start_m = 1'b1;
    @(posedge clk); #1;
    start_m = 1'b0;
  endtask

  // Cycle 1 is the cycle right after the start edge.
  task automatic wait_done_m(input string name, output int c);
    c = 1;
    while (done_m !== 1'b1 && c < 3000) begin
      @(posedge clk); #1;
      c++;
    end
    if (done_m !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: done never rose within %0d cycles", name, c);
    end
  endtask

  typedef struct {
    logic [9:0][63:0] data;
    int unsigned      exp_pass;
    int unsigned      exp_swap;
    int unsigned      exp_done;   // 0 = cycle not checked
    bit               stall;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int c, wc;
    int cs, cu, co;
    logic [9:0][63:0] rst_img, exp_img;

    reset = 1'b1; start_m = 1'b0; start_s = 1'b0;
    load_m = 1'b0; load_sm = 1'b0; load_img = '0; img2 = '0;
    gnt_m = 1'b1; stall_mode = 1'b0; gcyc = 0;

    for (int k = 0; k < 10; k++) begin
      vecs[0].data[k] = 64'(9 - k);
      vecs[1].data[k] = 64'(k);
      vecs[2].data[k] = 64'(k + 1);
      vecs[3].data[k] = 64'(9 - k);
      vecs[4].data[k] = (k == 0) ? 64'h8000_0000_0000_0000 : 64'(k - 1);
    end
    vecs[2].data[0] = 64'd3; vecs[2].data[1] = 64'd1; vecs[2].data[2] = 64'd2;
    vecs[0].exp_pass = 9; vecs[0].exp_swap = 45; vecs[0].exp_done = 226; vecs[0].stall = 1'b0;
    vecs[1].exp_pass = 1; vecs[1].exp_swap = 0;  vecs[1].exp_done = 28;  vecs[1].stall = 1'b0;
    vecs[2].exp_pass = 2; vecs[2].exp_swap = 2;  vecs[2].exp_done = 56;  vecs[2].stall = 1'b0;
    vecs[3].exp_pass = 9; vecs[3].exp_swap = 45; vecs[3].exp_done = 0;   vecs[3].stall = 1'b1;
    vecs[4].exp_pass = 2; vecs[4].exp_swap = 9;  vecs[4].exp_done = 70;  vecs[4].stall = 1'b0;

    #3 reset = 1'b0;
    #4;
    check("reset busy",    64'(busy_m), 64'd0);
    check("reset done",    64'(done_m), 64'd0);
    check("reset strobes", 64'({bus_m.mem_req, bus_m.memoryread, bus_m.memorywrite}), 64'd0);
    check("reset address", bus_m.address, 64'd0);
    check("reset wdata",   bus_m.write_data, 64'd0);
    check("reset counts",  64'({pass_m, swap_m}), 64'd0);
    @(negedge clk); reset = 1'b1;

    for (int v = 0; v < 5; v++) begin
      preload(vecs[v].data);
      stall_mode = vecs[v].stall;
      pulse_start_m();
      check($sformatf("v%0d busy rise", v), 64'(busy_m), 64'd1);
      wait_done_m($sformatf("v%0d", v), c);
      if (vecs[v].exp_done != 0)
        check($sformatf("v%0d done cycle", v), 64'(c), 64'(vecs[v].exp_done));
      @(posedge clk); #1;
      stall_mode = 1'b0;
      check($sformatf("v%0d busy fall", v), 64'({busy_m, done_m}), 64'd0);
      check($sformatf("v%0d pass_count", v), 64'(pass_m), 64'(vecs[v].exp_pass));
      check($sformatf("v%0d swap_count", v), 64'(swap_m), 64'(vecs[v].exp_swap));
      check_mem($sformatf("v%0d memory", v), model_sort(vecs[v].data));
    end

    // Reset lands in WR_B of the fifth swap of the reverse-order sort.
    preload(vecs[0].data);
    pulse_start_m();
    wc = 0; c = 1;
    while (c < 3000) begin
      if (bus_m.memorywrite) wc++;
      if (wc == 10) break;
      @(posedge clk); #1;
      c++;
    end
    check("wr_b5 reached", 64'(wc), 64'd10);
    check("wr_b5 address", bus_m.address, 64'd40);
    check("wr_b5 wdata",   bus_m.write_data, 64'd9);
    reset = 1'b0;
    #1;
    check("mid reset strobes", 64'({bus_m.mem_req, bus_m.memoryread, bus_m.memorywrite}), 64'd0);
    check("mid reset status",  64'({busy_m, done_m, pass_m, swap_m}), 64'd0);
    check("mid reset bus",     bus_m.address | bus_m.write_data, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("held reset", 64'({busy_m, bus_m.mem_req, bus_m.memorywrite}) | bus_m.address, 64'd0);
    for (int k = 0; k < 10; k++) rst_img[k] = 64'(9 - k);
    rst_img[4] = 64'd4; rst_img[0] = 64'd8; rst_img[1] = 64'd7; rst_img[2] = 64'd6; rst_img[3] = 64'd5;
    check_mem("memory after reset", rst_img);
    @(negedge clk); reset = 1'b1;

    pulse_start_m();
    wait_done_m("resort", c);
    exp_img = model_sort(rst_img);
    check_mem("resort memory", exp_img);
    check("resort swaps", 64'(swap_m), 64'(inversions(rst_img)));

    // Two-word signed/unsigned sorts and the N=1 instance, started together.
    img2[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    img2[1] = 64'd5;
    @(negedge clk); load_sm = 1'b1;
    @(posedge clk); #1; load_sm = 1'b0;
    @(negedge clk); start_s = 1'b1;
    @(posedge clk); #1; start_s = 1'b0;
    cs = 0; cu = 0; co = 0;
    for (int k = 1; k <= 12; k++) begin
      if (done_s && cs == 0) cs = k;
      if (done_u && cu == 0) cu = k;
      if (done_o && co == 0) co = k;
      @(posedge clk); #1;
    end
    check("signed done cycle",   64'(cs), 64'd4);
    check("unsigned done cycle", 64'(cu), 64'd6);
    check("n1 done cycle",       64'(co), 64'd1);
    check("signed word0",   mem_s[0], 64'hFFFF_FFFF_FFFF_FFFF);
    check("signed word1",   mem_s[1], 64'd5);
    check("unsigned word0", mem_u[0], 64'd5);
    check("unsigned word1", mem_u[1], 64'hFFFF_FFFF_FFFF_FFFF);
    check("signed counts",   64'({pass_s, swap_s}), 64'h0001_0000);
    check("unsigned counts", 64'({pass_u, swap_u}), 64'h0001_0001);
    check("n1 counts",       64'({pass_o, swap_o}), 64'd0);
    check("small idle",      64'({busy_s, busy_u, busy_o}), 64'd0);

    check("stall/strobe rule", 64'(viol_m), 64'd0);
    check("n1 no memory access", 64'(viol_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
